// File: rtl/uart_tx_fifo.sv
// 8N1 serial transmitter fed by a small write FIFO.
// The head byte is popped at frame start, so one extra byte can live in the shifter.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            Clock,
  input  logic                            nReset,
  input  logic                            WriteEnable,
  input  logic [7:0]                      WriteData,
  output logic                            Full,
  output logic                            Empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] Count,
  output logic                            Busy,
  output logic                            TxD
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [1:0]    r_state;
  logic [BW-1:0] r_bitcnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_txd;
  logic          r_busy;

  logic [PW-1:0] w_diff;
  logic          w_full;
  logic          w_empty;
  logic          w_wr;
  logic          w_pop;
  logic          w_bit_end;
  logic [7:0]    w_head;
  logic [1:0]    w_state_nx;
  logic [BW-1:0] w_bitcnt_nx;
  logic [2:0]    w_idx_nx;
  logic [7:0]    w_shift_nx;
  logic          w_txd_nx;

  assign w_diff    = r_wptr - r_rptr;
  assign Count     = CW'(w_diff);
  assign w_full    = (Count == CNT_FULL);
  assign w_empty   = (r_wptr == r_rptr);
  assign w_wr      = WriteEnable & ~w_full;
  assign w_bit_end = (r_bitcnt == BIT_LAST);
  assign w_head    = r_mem[r_rptr[AW-1:0]];

  assign Full  = w_full;
  assign Empty = w_empty;
  assign Busy  = r_busy;
  assign TxD   = r_txd;

  // Frame sequencer: next state, bit timing, shifter and line level.
  always_comb begin
    w_state_nx  = r_state;
    w_bitcnt_nx = r_bitcnt;
    w_idx_nx    = r_idx;
    w_shift_nx  = r_shift;
    w_pop       = 1'b0;
    w_txd_nx    = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_txd_nx = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nx  = w_head;
          w_bitcnt_nx = '0;
          w_state_nx  = ST_START;
        end else begin
          w_state_nx  = ST_IDLE;
        end
      end
      ST_START: begin
        w_txd_nx = 1'b0;
        if (w_bit_end) begin
          w_bitcnt_nx = '0;
          w_idx_nx    = 3'd0;
          w_state_nx  = ST_DATA;
        end else begin
          w_bitcnt_nx = r_bitcnt + BIT_ONE;
        end
      end
      ST_DATA: begin
        w_txd_nx = r_shift[0];
        if (w_bit_end) begin
          w_bitcnt_nx = '0;
          w_shift_nx  = r_shift >> 1;
          w_idx_nx    = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_nx = ST_STOP;
          end else begin
            w_state_nx = ST_DATA;
          end
        end else begin
          w_bitcnt_nx = r_bitcnt + BIT_ONE;
        end
      end
      ST_STOP: begin
        w_txd_nx = 1'b1;
        if (w_bit_end) begin
          w_bitcnt_nx = '0;
          // Chain straight into the next start bit when more data is queued
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_shift_nx = w_head;
            w_state_nx = ST_START;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end else begin
          w_bitcnt_nx = r_bitcnt + BIT_ONE;
        end
      end
      default: begin
        w_state_nx  = ST_IDLE;
        w_bitcnt_nx = '0;
        w_txd_nx    = 1'b1;
      end
    endcase
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge Clock) begin
    if (w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= WriteData;
    end
  end

  // Pointers, sequencer state and registered line outputs.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_state  <= ST_IDLE;
      r_bitcnt <= '0;
      r_idx    <= 3'd0;
      r_shift  <= 8'h00;
      r_txd    <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      r_state  <= w_state_nx;
      r_bitcnt <= w_bitcnt_nx;
      r_idx    <= w_idx_nx;
      r_shift  <= w_shift_nx;
      r_txd    <= w_txd_nx;
      r_busy   <= (r_state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a cycle-level occupancy/frame-timer model
// feeds an expected-byte queue that a serial-line decoder drains and compares.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic       WriteEnable = 1'b0;
  logic [7:0] WriteData = 8'h00;
  logic       Full, Empty, Busy, TxD;
  logic [2:0] Count;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .Clock(Clock), .nReset(nReset), .WriteEnable(WriteEnable), .WriteData(WriteData),
    .Full(Full), .Empty(Empty), .Count(Count), .Busy(Busy), .TxD(TxD)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO occupancy plus remaining cycles of the current frame.
  int         m_size = 0;
  int         m_rem  = 0;
  logic       m_busy = 1'b0;
  logic [7:0] exp_q[$];

  initial forever begin
    @(posedge Clock or negedge nReset);
    if (!nReset) begin
      m_size = 0;
      m_rem  = 0;
      m_busy = 1'b0;
      exp_q.delete();
    end else begin
      automatic bit pop = (m_size > 0) && (m_rem <= 1);
      automatic bit acc = (WriteEnable === 1'b1) && (m_size < DEPTH);
      m_busy = (m_rem > 0);
      if (pop) m_rem = FRAME;
      else if (m_rem > 0) m_rem--;
      m_size = m_size + (acc ? 1 : 0) - (pop ? 1 : 0);
      if (acc) exp_q.push_back(WriteData);
    end
  end

  // Per-cycle status comparison against the model.
  initial forever begin
    @(negedge Clock);
    if (nReset) begin
      check("count", 64'(Count), 64'(m_size));
      check("full",  64'(Full),  64'(m_size == DEPTH));
      check("empty", 64'(Empty), 64'(m_size == 0));
      check("busy",  64'(Busy),  64'(m_busy));
    end
  end

  // Serial-line monitor: decodes 8N1 frames at bit centres and pops the scoreboard.
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;
  int         frames_seen = 0;

  initial forever begin
    @(negedge Clock);
    if (!nReset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (TxD === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % CPB == CPB / 2) begin
        automatic int b = mon_cnt / CPB;
        if (b == 0) begin
          check("start_bit", 64'(TxD), 64'd0);
        end else if (b <= 8) begin
          mon_byte[b-1] = TxD;
        end else begin
          check("stop_bit", 64'(TxD), 64'd1);
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 64'(mon_byte), 64'hFFFF);
          end else begin
            check("rx_byte", 64'(mon_byte), 64'(exp_q.pop_front()));
          end
          frames_seen++;
          mon_active = 1'b0;
        end
      end
    end
  end

  // Called at a negedge; returns at the following negedge with the strobe low.
  task automatic write_byte(input logic [7:0] b);
    WriteEnable = 1'b1;
    WriteData   = b;
    @(negedge Clock);
    WriteEnable = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 1000; i++) begin
      if (exp_q.size() == 0 && m_size == 0 && m_rem == 0 && !mon_active && Busy === 1'b0) break;
      @(negedge Clock);
    end
    check(name, 64'(i < 1000), 64'd1);
    repeat (3) @(negedge Clock);
  endtask

  task automatic pulse_reset();
    #1 nReset = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge Clock);
    #1 nReset = 1'b1;
    @(negedge Clock);
  endtask

  initial begin
    int bad, busy_n, rises, f0;
    logic prev;
    logic [39:0] pat, exp_pat;
    logic [9:0]  frame;

    // Reset state and idle behaviour
    repeat (2) @(negedge Clock);
    check("rst_txd", 64'(TxD), 64'd1);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_full", 64'(Full), 64'd0);
    check("rst_empty", 64'(Empty), 64'd1);
    check("rst_count", 64'(Count), 64'd0);
    #1 nReset = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge Clock);
      if (TxD !== 1'b1 || Busy !== 1'b0 || Empty !== 1'b1 || Count !== 3'd0) bad++;
    end
    check("idle_quiet", 64'(bad), 64'd0);

    // Single 0x55: latency, bit pattern, busy length
    write_byte(8'h55);
    @(negedge Clock);
    check("lat_e1_txd", 64'(TxD), 64'd1);
    check("lat_e1_busy", 64'(Busy), 64'd0);
    @(negedge Clock);
    frame = {1'b1, 8'h55, 1'b0};
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      pat[i] = TxD;
      exp_pat[i] = frame[i / CPB];
      if (Busy === 1'b1) busy_n++;
      @(negedge Clock);
    end
    for (int i = 0; i < 10; i++) begin
      if (Busy === 1'b1) busy_n++;
      @(negedge Clock);
    end
    check("pattern_55", 64'(pat), 64'(exp_pat));
    check("busy_len_55", 64'(busy_n), 64'd40);
    drain("drain_55");

    // Two back-to-back frames
    f0 = frames_seen;
    write_byte(8'hA3);
    write_byte(8'h0F);
    busy_n = 0; rises = 0; prev = 1'b0;
    repeat (100) begin
      if (Busy === 1'b1) busy_n++;
      if (Busy === 1'b1 && prev !== 1'b1) rises++;
      prev = Busy;
      @(negedge Clock);
    end
    check("busy_len_pair", 64'(busy_n), 64'd80);
    check("busy_contiguous", 64'(rises), 64'd1);
    drain("drain_pair");
    check("frames_pair", 64'(frames_seen - f0), 64'd2);

    // Overflow: six writes, sixth dropped
    f0 = frames_seen;
    for (int i = 1; i <= 6; i++) write_byte(8'(i));
    check("full_after_burst", 64'(Full), 64'd1);
    check("count_after_burst", 64'(Count), 64'd4);
    drain("drain_overflow");
    check("frames_overflow", 64'(frames_seen - f0), 64'd5);

    // Reset during DATA of 0xFF with two bytes queued
    write_byte(8'hFF);
    write_byte(8'h11);
    write_byte(8'h22);
    repeat (10) @(negedge Clock);
    check("pre_rst_busy", 64'(Busy), 64'd1);
    check("pre_rst_count", 64'(Count), 64'd2);
    pulse_reset();
    check("async_rst_txd", 64'(TxD), 64'd1);
    check("async_rst_busy", 64'(Busy), 64'd0);
    check("async_rst_count", 64'(Count), 64'd0);
    release_reset();
    bad = 0;
    repeat (60) begin
      if (Busy !== 1'b0 || TxD !== 1'b1) bad++;
      @(negedge Clock);
    end
    check("no_resume", 64'(bad), 64'd0);

    // Reset during a start bit: line must return high without a clock edge
    write_byte(8'h3C);
    repeat (2) @(negedge Clock);
    check("start_low", 64'(TxD), 64'd0);
    pulse_reset();
    check("async_rst_start_txd", 64'(TxD), 64'd1);
    release_reset();
    drain("drain_after_reset");

    // Write coinciding with a STOP->START pop at Count=2
    f0 = frames_seen;
    write_byte(8'h10);
    write_byte(8'h20);
    write_byte(8'h30);
    bad = 1;
    for (int i = 0; i < 100; i++) begin
      if (m_rem == 1 && m_size == 2) begin bad = 0; break; end
      @(negedge Clock);
    end
    check("found_pop_edge", 64'(bad), 64'd0);
    write_byte(8'h40);
    check("count_hold_2", 64'(Count), 64'd2);
    drain("drain_coincide");
    check("frames_coincide", 64'(frames_seen - f0), 64'd4);

    // Randomized bursts with gaps
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(0, 30)) @(negedge Clock);
      for (int j = 0; j < int'($urandom_range(1, 4)); j++) write_byte(8'($urandom));
    end
    drain("drain_random");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
